// File: rtl/accel_loader.sv
// Byte-stream loader: packs upstream bytes into 64-bit picture/weight words, launches
// the accelerator once per image and returns its label. Optional WAIT watchdog: ACCEL_LOADER_TIMEOUT_EN.
module accel_loader #(
  parameter int PIC_WORDS      = 98,
  parameter int WGT_WORDS      = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_sel,
  output logic        pic_we,
  output logic [6:0]  pic_addr,
  output logic [63:0] pic_data,
  output logic        wgt_we,
  output logic [6:0]  wgt_addr,
  output logic [63:0] wgt_data,
  output logic        acc_start,
  input  logic        acc_busy,
  input  logic        acc_done,
  input  logic [3:0]  acc_label,
  output logic [3:0]  label_out,
  output logic        label_valid,
  input  logic        label_ready,
  output logic        sel_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t      state_q;
  logic        s_ready_q;
  logic [2:0]  byte_cnt_q;
  logic        sel_q;
  logic [63:0] word_q;
  logic [6:0]  pic_cnt_q;
  logic [6:0]  wgt_cnt_q;
  logic        last_q;
  logic        pic_we_q;
  logic [6:0]  pic_addr_q;
  logic [63:0] pic_data_q;
  logic        wgt_we_q;
  logic [6:0]  wgt_addr_q;
  logic [63:0] wgt_data_q;
  logic        acc_start_q;
  logic [3:0]  label_q;
  logic        label_valid_q;
  logic        sel_err_q;

`ifdef ACCEL_LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q;
`endif

  logic        accept_d;
  logic        mismatch_d;
  logic [2:0]  slot_d;
  logic        full_d;
  logic        sel_d;
  logic [63:0] word_d;
  logic [6:0]  wgt_cnt_d;

  // A mismatching byte restarts the word in slot 0; stale upper bytes are always overwritten.
  always_comb begin
    accept_d   = s_valid & s_ready_q;
    mismatch_d = accept_d && (byte_cnt_q != 3'd0) && (s_sel != sel_q);
    slot_d     = mismatch_d ? 3'd0 : byte_cnt_q;
    full_d     = accept_d && (slot_d == 3'd7);
    if (byte_cnt_q == 3'd0 || mismatch_d) begin
      sel_d = s_sel;
    end else begin
      sel_d = sel_q;
    end
    word_d = word_q;
    word_d[{slot_d, 3'b000} +: 8] = s_data;
    if (wgt_cnt_q == 7'(WGT_WORDS - 1)) begin
      wgt_cnt_d = 7'd0;
    end else begin
      wgt_cnt_d = wgt_cnt_q + 7'd1;
    end
  end

  // Control FSM together with the packing datapath and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b1;
      byte_cnt_q    <= 3'd0;
      sel_q         <= 1'b0;
      word_q        <= 64'd0;
      pic_cnt_q     <= 7'd0;
      wgt_cnt_q     <= 7'd0;
      last_q        <= 1'b0;
      pic_we_q      <= 1'b0;
      pic_addr_q    <= 7'd0;
      pic_data_q    <= 64'd0;
      wgt_we_q      <= 1'b0;
      wgt_addr_q    <= 7'd0;
      wgt_data_q    <= 64'd0;
      acc_start_q   <= 1'b0;
      label_q       <= 4'd0;
      label_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
`ifdef ACCEL_LOADER_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      pic_we_q    <= 1'b0;
      wgt_we_q    <= 1'b0;
      sel_err_q   <= 1'b0;
      acc_start_q <= 1'b0;
      last_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          label_valid_q <= 1'b0;
          if (last_q) begin
            state_q <= START;
          end
          if (accept_d) begin
            word_q     <= word_d;
            sel_q      <= sel_d;
            sel_err_q  <= mismatch_d;
            byte_cnt_q <= full_d ? 3'd0 : slot_d + 3'd1;
          end
          if (full_d) begin
            if (sel_d) begin
              wgt_we_q   <= 1'b1;
              wgt_addr_q <= wgt_cnt_q;
              wgt_data_q <= word_d;
              wgt_cnt_q  <= wgt_cnt_d;
            end else begin
              pic_we_q   <= 1'b1;
              pic_addr_q <= pic_cnt_q;
              pic_data_q <= word_d;
              pic_cnt_q  <= pic_cnt_q + 7'd1;
              // Final picture word: stop accepting now, launch once the write is out.
              if (pic_cnt_q == 7'(PIC_WORDS - 1)) begin
                last_q    <= 1'b1;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        START: begin
          if (!acc_busy) begin
            acc_start_q <= 1'b1;
            state_q     <= WAIT;
`ifdef ACCEL_LOADER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end
        end
        WAIT: begin
          if (acc_done) begin
            label_q       <= acc_label;
            label_valid_q <= 1'b1;
            state_q       <= RESULT;
          end
`ifdef ACCEL_LOADER_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            label_q       <= 4'hF;
            label_valid_q <= 1'b1;
            pic_cnt_q     <= 7'd0;
            s_ready_q     <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        RESULT: begin
          if (label_valid_q && label_ready) begin
            label_valid_q <= 1'b0;
            pic_cnt_q     <= 7'd0;
            s_ready_q     <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign pic_we      = pic_we_q;
  assign pic_addr    = pic_addr_q;
  assign pic_data    = pic_data_q;
  assign wgt_we      = wgt_we_q;
  assign wgt_addr    = wgt_addr_q;
  assign wgt_data    = wgt_data_q;
  assign acc_start   = acc_start_q;
  assign label_out   = label_q;
  assign label_valid = label_valid_q;
  assign sel_err     = sel_err_q;

endmodule
